// File: rtl/l2_tlb_victim_sel.sv
// L2 TLB replacement: per-set tree-PLRU state and victim offer
// to the PTW refill path, held until the refill completes.
module l2_tlb_victim_sel #(
  parameter int NSETS    = 8,
  parameter int SET_BITS = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic                hit_valid_i,
  input  logic [SET_BITS-1:0] hit_set_i,
  input  logic [3:0]          hit_way_i,
  input  logic                miss_valid_i,
  output logic                miss_ready_o,
  input  logic [SET_BITS-1:0] miss_set_i,
  input  logic [3:0]          miss_way_valid_i,
  output logic                victim_valid_o,
  input  logic                victim_ready_i,
  output logic [SET_BITS-1:0] victim_set_o,
  output logic [1:0]          victim_way_o,
  output logic [3:0]          victim_oh_o,
  input  logic                refill_done_i
);

  typedef enum logic [1:0] {
    IDLE, LOOKUP, OFFER, WAIT_FILL
  } state_e;

  state_e                    state_q, state_d;
  logic [NSETS-1:0][2:0]     plru_q, plru_d;
  logic [SET_BITS-1:0]       set_q, set_d;
  logic [3:0]                vld_q, vld_d;
  logic [1:0]                way_q, way_d;
  logic                      fill_touch;

  function automatic logic [1:0] lowest(
    input logic [3:0] v
  );
    logic [1:0] r;
    if (v[0])      r = 2'd0;
    else if (v[1]) r = 2'd1;
    else if (v[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

  // Point the tree away from way w.
  function automatic logic [2:0] touch(
    input logic [2:0] s,
    input logic [1:0] w
  );
    logic [2:0] r;
    r = s;
    unique case (w)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      2'd3: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

  // An invalid way always beats the PLRU choice.
  function automatic logic [1:0] pick(
    input logic [2:0] s,
    input logic [3:0] v
  );
    logic [1:0] r;
    if (!(&v))     r = lowest(~v);
    else if (s[0]) r = s[2] ? 2'd3 : 2'd2;
    else           r = s[1] ? 2'd1 : 2'd0;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    vld_d   = vld_q;
    way_d   = way_q;
    unique case (state_q)
      IDLE: begin
        if (miss_valid_i) begin
          set_d   = miss_set_i;
          vld_d   = miss_way_valid_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        way_d   = pick(plru_q[set_q], vld_q);
        state_d = OFFER;
      end
      OFFER: begin
        if (victim_ready_i) state_d = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (refill_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  assign fill_touch = (state_q == WAIT_FILL) && refill_done_i;

  // Hit touch first, refill touch second, so the refill wins.
  always_comb begin
    plru_d = plru_q;
    for (int i = 0; i < NSETS; i++) begin
      if (hit_valid_i && (|hit_way_i) &&
          hit_set_i == SET_BITS'(i))
        plru_d[i] = touch(plru_d[i], lowest(hit_way_i));
      if (fill_touch && set_q == SET_BITS'(i))
        plru_d[i] = touch(plru_d[i], way_q);
    end
    if (flush_i) plru_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      plru_q  <= '0;
      set_q   <= '0;
      vld_q   <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      plru_q  <= plru_d;
      set_q   <= set_d;
      vld_q   <= vld_d;
      way_q   <= way_d;
    end
  end

  assign miss_ready_o   = (state_q == IDLE);
  assign victim_valid_o = (state_q == OFFER);
  assign victim_set_o   = set_q;
  assign victim_way_o   = way_q;
  assign victim_oh_o    = 4'b0001 << way_q;

endmodule

// File: tb/tb_l2_tlb_victim_sel.sv
// Bench for l2_tlb_victim_sel: directed scenarios, then
// randomized traffic against a tree-PLRU reference model.
module tb_l2_tlb_victim_sel;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic       hit_valid;
  logic [2:0] hit_set;
  logic [3:0] hit_way;
  logic       miss_valid, miss_ready;
  logic [2:0] miss_set;
  logic [3:0] miss_way_valid;
  logic       victim_valid, victim_ready;
  logic [2:0] victim_set;
  logic [1:0] victim_way;
  logic [3:0] victim_oh;
  logic       refill_done;

  l2_tlb_victim_sel #(.NSETS(8), .SET_BITS(3)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .flush_i          (flush),
    .hit_valid_i      (hit_valid),
    .hit_set_i        (hit_set),
    .hit_way_i        (hit_way),
    .miss_valid_i     (miss_valid),
    .miss_ready_o     (miss_ready),
    .miss_set_i       (miss_set),
    .miss_way_valid_i (miss_way_valid),
    .victim_valid_o   (victim_valid),
    .victim_ready_i   (victim_ready),
    .victim_set_o     (victim_set),
    .victim_way_o     (victim_way),
    .victim_oh_o      (victim_oh),
    .refill_done_i    (refill_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: per set, which pair is older and which way in each pair.
  bit half [8];
  bit lo   [8];
  bit hi   [8];
  bit fill_armed;
  int fill_set, fill_way;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      half[i] = 0; lo[i] = 0; hi[i] = 0;
    end
    fill_armed = 0;
  endtask

  task automatic model_touch(input int set, input int w);
    half[set] = (w < 2);
    if (w < 2) lo[set] = (w == 0);
    else       hi[set] = (w == 2);
  endtask

  function automatic int low_bit(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return 3;
  endfunction

  function automatic int model_victim(input int set,
                                      input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (!v[i]) return i;
    return half[set] ? 2 + int'(hi[set]) : int'(lo[set]);
  endfunction

  task automatic tick();
    if (flush) begin
      model_clear();
    end else begin
      if (hit_valid && hit_way != 4'd0)
        model_touch(int'(hit_set), low_bit(hit_way));
      if (refill_done && fill_armed) begin
        model_touch(fill_set, fill_way);
        fill_armed = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0 none, 1 random, 2 hit victim way, 3 hit way 2 at refill
  task automatic drive_hit(input int mode, input int set,
                           input int way, input bit rcyc);
    hit_valid = 1'b0;
    hit_set   = 3'(set);
    hit_way   = 4'd0;
    case (mode)
      1: begin
        hit_valid = 1'($urandom_range(0, 1));
        hit_set   = 3'($urandom_range(0, 7));
        hit_way   = 4'($urandom);
      end
      2: if (way >= 0) begin
        hit_valid = 1'b1;
        hit_way   = 4'(1 << way);
      end
      3: if (rcyc) begin
        hit_valid = 1'b1;
        hit_way   = 4'b0100;
      end
      default: ;
    endcase
  endtask

  task automatic chk_offer(input string tag, input int set,
                           input int way);
    chk({tag, "_vv"},  32'(victim_valid), 1);
    chk({tag, "_set"}, 32'(victim_set), 32'(set));
    chk({tag, "_way"}, 32'(victim_way), 32'(way));
    chk({tag, "_oh"},  32'(victim_oh), 32'(1 << way));
  endtask

  task automatic do_miss(input string tag, input int set,
                         input logic [3:0] v, input int hold,
                         input int gap, input int mode);
    int way;
    chk({tag, "_rdy"}, 32'(miss_ready), 1);
    miss_valid     = 1'b1;
    miss_set       = 3'(set);
    miss_way_valid = v;
    drive_hit(mode, set, -1, 0);
    tick();
    miss_valid     = 1'b0;
    miss_way_valid = 4'($urandom);
    chk({tag, "_lk_vv"},  32'(victim_valid), 0);
    chk({tag, "_lk_rdy"}, 32'(miss_ready), 0);
    way = model_victim(set, v);
    drive_hit(mode, set, -1, 0);
    tick();
    chk_offer(tag, set, way);
    for (int k = 0; k < hold; k++) begin
      victim_ready = 1'b0;
      miss_valid   = 1'($urandom_range(0, 1));
      miss_set     = 3'($urandom_range(0, 7));
      refill_done  = 1'($urandom_range(0, 1));
      drive_hit(mode, set, way, 0);
      tick();
      chk_offer({tag, "_hold"}, set, way);
    end
    refill_done  = 1'b0;
    victim_ready = 1'b1;
    drive_hit(mode, set, way, 0);
    tick();
    victim_ready = 1'b0;
    chk({tag, "_wf_vv"},  32'(victim_valid), 0);
    chk({tag, "_wf_rdy"}, 32'(miss_ready), 0);
    for (int k = 0; k < gap; k++) begin
      drive_hit(mode, set, way, 0);
      tick();
      chk({tag, "_gap_rdy"}, 32'(miss_ready), 0);
    end
    fill_armed  = 1;
    fill_set    = set;
    fill_way    = way;
    refill_done = 1'b1;
    drive_hit(mode, set, way, 1);
    tick();
    refill_done = 1'b0;
    miss_valid  = 1'b0;
    hit_valid   = 1'b0;
    chk({tag, "_done_rdy"}, 32'(miss_ready), 1);
    chk({tag, "_done_vv"},  32'(victim_valid), 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    hit_valid = 1'b0; hit_set = '0; hit_way = '0;
    miss_valid = 1'b0; miss_set = '0; miss_way_valid = '0;
    victim_ready = 1'b0; refill_done = 1'b0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_rdy", 32'(miss_ready), 1);
    chk("rst_vv",  32'(victim_valid), 0);
    chk("rst_set", 32'(victim_set), 0);
    chk("rst_way", 32'(victim_way), 0);
    chk("rst_oh",  32'(victim_oh), 32'h1);
    reset = 1'b0;
    tick();

    do_miss("t1", 3, 4'b1111, 0, 0, 0);
    do_miss("t1b", 3, 4'b1111, 1, 1, 0);

    for (int w = 0; w < 3; w++) begin
      hit_valid = 1'b1;
      hit_set   = 3'd5;
      hit_way   = 4'(1 << w);
      tick();
    end
    hit_valid = 1'b0;
    do_miss("t2a", 5, 4'b1111, 0, 0, 0);
    do_miss("t2b", 5, 4'b1111, 0, 0, 0);

    do_miss("t3", 2, 4'b1011, 0, 0, 1);
    do_miss("t4", 1, 4'b1111, 5, 1, 2);
    do_miss("t5", 4, 4'b1110, 0, 0, 3);
    do_miss("t5b", 4, 4'b1111, 0, 0, 0);

    miss_valid = 1'b1; miss_set = 3'd5;
    miss_way_valid = 4'b1111;
    tick();
    miss_valid = 1'b0;
    tick();
    chk("t6_offer", 32'(victim_valid), 1);
    flush = 1'b1;
    hit_valid = 1'b1; hit_set = 3'd5; hit_way = 4'b0010;
    tick();
    flush = 1'b0; hit_valid = 1'b0;
    chk("t6_vv",  32'(victim_valid), 0);
    chk("t6_rdy", 32'(miss_ready), 1);
    refill_done = 1'b1;
    tick();
    refill_done = 1'b0;
    chk("t6_ign_rdy", 32'(miss_ready), 1);
    do_miss("t6a", 5, 4'b1111, 0, 0, 0);
    do_miss("t6b", 3, 4'b1111, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] v;
      v = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom);
      do_miss("rnd", int'($urandom_range(0, 7)), v,
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
